// File: rtl/dcache_pkg.sv
// Shared types and helpers for the L1 data-cache data-RAM sequencer.
package dcache_pkg;

  localparam int LINE_WORDS = 8;
  localparam int OFF_W      = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    WB_RD   = 2'd2,
    WB_HOLD = 2'd3
  } state_e;

  // One-hot way enable.
  function automatic logic [1:0] way_en(input logic way);
    return way ? 2'b10 : 2'b01;
  endfunction

  // Place 4 byte enables into the lane of the addressed way.
  function automatic logic [7:0] way_wen(input logic way, input logic [3:0] be);
    return way ? {be, 4'h0} : {4'h0, be};
  endfunction

endpackage

// File: rtl/dcache_data_ctrl_if.sv
// Requester and data-RAM signals of the data-RAM sequencer.
interface dcache_data_ctrl_if #(
  parameter int ADDR_W = 12
) ();
  localparam int IDX_W = ADDR_W - dcache_pkg::OFF_W;

  // CPU lookups
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [3:0]        cpu_we;
  logic              cpu_way;
  logic [31:0]       cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [31:0]       cpu_rdata0;
  logic [31:0]       cpu_rdata1;
  // line refill
  logic              fill_req;
  logic              fill_way;
  logic [IDX_W-1:0]  fill_index;
  logic              fill_valid;
  logic [31:0]       fill_data;
  logic              fill_ready;
  logic              fill_done;
  // victim writeback
  logic              wb_req;
  logic              wb_way;
  logic [IDX_W-1:0]  wb_index;
  logic              wb_valid;
  logic [31:0]       wb_data;
  logic              wb_ready;
  logic              wb_done;
  // data RAM
  logic [ADDR_W-1:0] ram_addr;
  logic [1:0]        ram_en;
  logic [7:0]        ram_wen;
  logic [31:0]       ram_w0;
  logic [31:0]       ram_w1;
  logic [31:0]       ram_r0;
  logic [31:0]       ram_r1;

  modport slave (
    input  cpu_req, cpu_addr, cpu_we, cpu_way, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata0, cpu_rdata1,
    input  fill_req, fill_way, fill_index, fill_valid, fill_data,
    output fill_ready, fill_done,
    input  wb_req, wb_way, wb_index, wb_ready,
    output wb_valid, wb_data, wb_done,
    output ram_addr, ram_en, ram_wen, ram_w0, ram_w1,
    input  ram_r0, ram_r1
  );

  modport master (
    output cpu_req, cpu_addr, cpu_we, cpu_way, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata0, cpu_rdata1,
    output fill_req, fill_way, fill_index, fill_valid, fill_data,
    input  fill_ready, fill_done,
    output wb_req, wb_way, wb_index, wb_ready,
    input  wb_valid, wb_data, wb_done,
    input  ram_addr, ram_en, ram_wen, ram_w0, ram_w1,
    output ram_r0, ram_r1
  );
endinterface

// File: rtl/dcache_line_counter.sv
// Beat counter within a cache line, shared by refill and writeback.
module dcache_line_counter
  import dcache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [OFF_W-1:0] cnt,
  output logic             last
);

  // Clear wins over increment; the counter wraps naturally after the last beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  end

  assign last = (cnt == OFF_W'(LINE_WORDS - 1));

endmodule

// File: rtl/dcache_data_ctrl.sv
// Arbiter/sequencer for the two-way data RAM: writeback > refill > CPU.
module dcache_data_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  dcache_data_ctrl_if.slave  bus
);

  state_e            state, state_d;
  logic [OFF_W-1:0]  cnt;
  logic              last, cnt_clr, cnt_inc;
  logic              cpu_gnt, fill_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic [1:0]        ram_en;
  logic [7:0]        ram_wen;
  logic              cpu_rvalid, fill_done, wb_done, wb_valid;
  logic              wb_first;
  logic [31:0]       wb_q, wb_sel;

  dcache_line_counter u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .cnt  (cnt),
    .last (last)
  );

  // Next state plus the single RAM port mux; nothing is enabled by default.
  always_comb begin
    state_d    = state;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    cpu_gnt    = 1'b0;
    fill_ready = 1'b0;
    ram_addr   = bus.cpu_addr;
    ram_en     = 2'b00;
    ram_wen    = 8'h00;
    unique case (state)
      IDLE: begin
        if (bus.wb_req) begin
          state_d = WB_RD;
          cnt_clr = 1'b1;
        end else if (bus.fill_req) begin
          state_d = FILL;
          cnt_clr = 1'b1;
        end else if (bus.cpu_req) begin
          cpu_gnt = 1'b1;
          if (bus.cpu_we == 4'h0) begin
            ram_en = 2'b11;
          end else begin
            ram_en  = way_en(bus.cpu_way);
            ram_wen = way_wen(bus.cpu_way, bus.cpu_we);
          end
        end
      end
      FILL: begin
        fill_ready = 1'b1;
        ram_addr   = {bus.fill_index, cnt};
        if (bus.fill_valid) begin
          ram_en  = way_en(bus.fill_way);
          ram_wen = way_wen(bus.fill_way, 4'hF);
          cnt_inc = 1'b1;
          if (last) state_d = IDLE;
        end
      end
      WB_RD: begin
        ram_addr = {bus.wb_index, cnt};
        ram_en   = way_en(bus.wb_way);
        state_d  = WB_HOLD;
      end
      WB_HOLD: begin
        if (bus.wb_ready) begin
          if (last) begin
            state_d = IDLE;
          end else begin
            cnt_inc = 1'b1;
            state_d = WB_RD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any line operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // Registered status pulses and the writeback beat holding register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rvalid <= 1'b0;
      fill_done  <= 1'b0;
      wb_done    <= 1'b0;
      wb_valid   <= 1'b0;
      wb_first   <= 1'b0;
      wb_q       <= '0;
    end else begin
      cpu_rvalid <= cpu_gnt & (bus.cpu_we == 4'h0);
      fill_done  <= (state == FILL) & bus.fill_valid & last;
      wb_done    <= (state == WB_HOLD) & bus.wb_ready & last;
      wb_valid   <= (state_d == WB_HOLD);
      wb_first   <= (state == WB_RD);
      if (wb_first) wb_q <= wb_sel;
    end
  end

  // The RAM word lands in the first hold cycle; after that the captured copy
  // keeps the beat stable no matter what the RAM output does.
  assign wb_sel = bus.wb_way ? bus.ram_r1 : bus.ram_r0;

  assign bus.wb_data    = wb_first ? wb_sel : wb_q;
  assign bus.wb_valid   = wb_valid;
  assign bus.wb_done    = wb_done;
  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.cpu_rvalid = cpu_rvalid;
  assign bus.cpu_rdata0 = bus.ram_r0;
  assign bus.cpu_rdata1 = bus.ram_r1;
  assign bus.fill_ready = fill_ready;
  assign bus.fill_done  = fill_done;
  assign bus.ram_addr   = ram_addr;
  assign bus.ram_en     = ram_en;
  assign bus.ram_wen    = ram_wen;
  assign bus.ram_w0     = (state == FILL) ? bus.fill_data : bus.cpu_wdata;
  assign bus.ram_w1     = (state == FILL) ? bus.fill_data : bus.cpu_wdata;

endmodule
